// File: rtl/fpu_issue.sv
// fpu_issue: issue/retire controller sitting between the integer pipeline and
// the FPU cluster. Requests are turned into one-cycle one-hot opcode pulses,
// and each in-flight op reserves the retire slot matching its latency so that
// at most one FPU result is due in any cycle.
module fpu_issue #(
    parameter int TAG_W    = 5,
    parameter int SLOT_N   = 8,
    parameter int LAT_ADD  = 3,
    parameter int LAT_SUB  = 3,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 3,
    parameter int LAT_FTOI = 1,
    parameter int LAT_ITOF = 2,
    parameter int LAT_FABS = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [7:0]       fpu_opcode,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_valid,
    output logic             resp_valid,
    output logic [31:0]      resp_y,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy
);

    localparam int IDX_W = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;

    // Result latency of each opcode, used as the retire-slot index.
    function automatic logic [IDX_W-1:0] lat_of(input logic [2:0] op);
        logic [IDX_W-1:0] l;
        case (op)
            3'd0:    l = IDX_W'(LAT_ADD);
            3'd1:    l = IDX_W'(LAT_SUB);
            3'd2:    l = IDX_W'(LAT_MUL);
            3'd3:    l = IDX_W'(LAT_DIV);
            3'd4:    l = IDX_W'(LAT_SQRT);
            3'd5:    l = IDX_W'(LAT_FTOI);
            3'd6:    l = IDX_W'(LAT_ITOF);
            default: l = IDX_W'(LAT_FABS);
        endcase
        return l;
    endfunction

    logic [SLOT_N-1:0] pend_v_q, pend_v_d;
    logic [TAG_W-1:0]  pend_tag_q [SLOT_N];
    logic [TAG_W-1:0]  pend_tag_d [SLOT_N];

    logic [7:0]        opcode_q;
    logic [31:0]       x1_q, x2_q;
    logic              resp_valid_q, resp_err_q;
    logic [31:0]       resp_y_q;
    logic [TAG_W-1:0]  resp_tag_q;

    logic [IDX_W-1:0]  req_lat;
    logic [IDX_W-1:0]  chk_idx;
    logic              accept;
    logic              retire;

    // The slot checked is one above the target because the register shifts
    // down on the same edge that the new entry is written.
    assign req_lat   = lat_of(req_op);
    assign chk_idx   = req_lat + IDX_W'(1);
    assign req_ready = !flush && !pend_v_q[chk_idx];
    assign accept    = req_valid && req_ready;
    // A flush in the due cycle drops the result instead of retiring it.
    assign retire    = pend_v_q[0] && !flush;

    // Next slot state: shift toward slot 0, insert the accepted op, flush clears all.
    always_comb begin
        pend_v_d = '0;
        for (int k = 0; k < SLOT_N; k++) begin
            pend_tag_d[k] = pend_tag_q[k];
        end
        for (int k = 0; k < SLOT_N - 1; k++) begin
            pend_v_d[k]   = pend_v_q[k+1];
            pend_tag_d[k] = pend_tag_q[k+1];
        end
        if (accept) begin
            pend_v_d[req_lat]   = 1'b1;
            pend_tag_d[req_lat] = req_tag;
        end
        if (flush) begin
            pend_v_d = '0;
        end
    end

    // Retire-slot registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_v_q <= '0;
            for (int k = 0; k < SLOT_N; k++) begin
                pend_tag_q[k] <= '0;
            end
        end else begin
            pend_v_q <= pend_v_d;
            for (int k = 0; k < SLOT_N; k++) begin
                pend_tag_q[k] <= pend_tag_d[k];
            end
        end
    end

    // Issue side: one-cycle one-hot opcode per accept, operands held between issues.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opcode_q <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
        end else begin
            opcode_q <= accept ? (8'd1 << req_op) : 8'd0;
            if (accept) begin
                x1_q <= req_x1;
                x2_q <= req_x2;
            end
        end
    end

    // Retire side: capture the FPU result in the cycle slot 0 says it is due.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            resp_y_q     <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= retire;
            if (retire) begin
                resp_y_q   <= fpu_y;
                resp_tag_q <= pend_tag_q[0];
                resp_err_q <= !fpu_valid;
            end
        end
    end

    assign fpu_opcode = opcode_q;
    assign fpu_x1     = x1_q;
    assign fpu_x2     = x2_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_tag   = resp_tag_q;
    assign resp_err   = resp_err_q;
    assign busy       = (|pend_v_q) || (|opcode_q);

endmodule

// File: tb/tb_fpu_issue.sv
// Scoreboard bench for fpu_issue: stimulus pushes expected responses, a monitor
// pops them whenever resp_valid is seen and also checks the opcode pulses.
module tb_fpu_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_x1, req_x2;
    logic [4:0]  req_tag;
    logic        flush;
    logic [7:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2;
    logic [31:0] fpu_y;
    logic        fpu_valid;
    logic        resp_valid;
    logic [31:0] resp_y;
    logic [4:0]  resp_tag;
    logic        resp_err;
    logic        busy;

    fpu_issue dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag), .flush(flush),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_valid(fpu_valid),
        .resp_valid(resp_valid), .resp_y(resp_y), .resp_tag(resp_tag),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge E it reads E.
    logic [10:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 11'd1;

    int LATS [8] = '{3, 3, 3, 6, 3, 1, 2, 1};

    // FPU model: results scheduled per cycle by the stimulus.
    bit          due_v  [2048];
    bit          due_ok [2048];
    logic [31:0] due_y  [2048];
    logic [7:0]  exp_opc [2048];
    logic [31:0] exp_x1 [2048];
    logic [31:0] exp_x2 [2048];

    assign fpu_valid = due_v[cyc] && due_ok[cyc];
    assign fpu_y     = due_v[cyc] ? due_y[cyc] : 32'hDEADBEEF;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        logic        err;
        logic [10:0] cyc;
    } exp_t;
    exp_t exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input bit ok, input string act, input string req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request until accepted; record the FPU schedule and expected response.
    task automatic issue(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [4:0] tag, input logic [31:0] y, input bit fpu_ok,
                         input bit expect_resp, output int waits, output logic [10:0] e);
        bit          accepted;
        logic [7:0]  one;
        logic [10:0] due_c;
        req_op = op; req_x1 = x1; req_x2 = x2; req_tag = tag; req_valid = 1'b1;
        waits = 0; accepted = 0; e = '0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            #1;
            if (req_ready) begin
                @(posedge clk);
                #1;
                accepted = 1;
            end else begin
                waits++;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        if (!accepted) begin
            chk("accept_timeout", 1'b0, "no accept", "accept within 40 cycles");
            return;
        end
        e = cyc;
        one = 8'd1;
        exp_opc[e] = one << op;
        exp_x1[e] = x1;
        exp_x2[e] = x2;
        due_c = e + 11'(LATS[op]);
        due_v[due_c] = 1'b1;
        due_ok[due_c] = fpu_ok;
        due_y[due_c] = y;
        if (expect_resp)
            exp_q.push_back('{y: y, tag: tag, err: !fpu_ok, cyc: due_c + 11'd1});
        $display("issue op=%0d tag=%0d x1=%h x2=%h accepted at edge %0d after %0d wait(s)",
                 op, tag, x1, x2, e, waits);
    endtask

    // Monitor: opcode pulse check every cycle, scoreboard pop on each response.
    initial begin
        exp_t ex;
        wait (rstn === 1'b1);
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                chk("opcode", fpu_opcode === exp_opc[cyc],
                    $sformatf("%h", fpu_opcode), $sformatf("%h", exp_opc[cyc]));
                if (exp_opc[cyc] != 8'd0)
                    chk("operands", fpu_x1 === exp_x1[cyc] && fpu_x2 === exp_x2[cyc],
                        $sformatf("%h/%h", fpu_x1, fpu_x2),
                        $sformatf("%h/%h", exp_x1[cyc], exp_x2[cyc]));
                if (resp_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 1'b0,
                            $sformatf("tag=%0d y=%h cyc=%0d", resp_tag, resp_y, cyc), "no response");
                    end else begin
                        ex = exp_q.pop_front();
                        $display("resp tag=%0d y=%h err=%0b cycle=%0d", resp_tag, resp_y, resp_err, cyc);
                        chk("resp", resp_y === ex.y && resp_tag === ex.tag &&
                                    resp_err === ex.err && cyc === ex.cyc,
                            $sformatf("y=%h tag=%0d err=%0b cyc=%0d", resp_y, resp_tag, resp_err, cyc),
                            $sformatf("y=%h tag=%0d err=%0b cyc=%0d", ex.y, ex.tag, ex.err, ex.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, w2;
        logic [10:0] e, e2;
        for (int i = 0; i < 2048; i++) begin
            exp_opc[i] = 8'd0; exp_x1[i] = '0; exp_x2[i] = '0; due_y[i] = '0;
        end
        rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_x1 = '0; req_x2 = '0;
        req_tag = '0; flush = 1'b0;
        idle(3);
        chk("reset_outputs", fpu_opcode === 8'd0 && fpu_x1 === 32'd0 && fpu_x2 === 32'd0 &&
                             resp_valid === 1'b0 && resp_y === 32'd0 && resp_tag === 5'd0 &&
                             resp_err === 1'b0 && busy === 1'b0,
            $sformatf("opc=%h x1=%h x2=%h rv=%b ry=%h rt=%0d re=%b busy=%b",
                      fpu_opcode, fpu_x1, fpu_x2, resp_valid, resp_y, resp_tag, resp_err, busy),
            "all zero");
        chk("reset_ready", req_ready === 1'b1, $sformatf("%b", req_ready), "1");
        rstn = 1'b1;
        idle(2);

        // fadd 1.0 + 2.0
        issue(3'd0, 32'h3F800000, 32'h40000000, 5'd5, 32'h40400000, 1, 1, w, e);
        chk("fadd_wait", w == 0, $sformatf("%0d", w), "0");
        idle(6);

        // Slot collision: fdiv holds slot 4 when the fadd is first presented.
        issue(3'd3, 32'h3F800000, 32'h40000000, 5'd1, 32'h3F000000, 1, 1, w, e);
        idle(2);
        issue(3'd0, 32'h40000000, 32'h40000000, 5'd2, 32'h40800000, 1, 1, w2, e2);
        chk("collision_wait", w2 == 1, $sformatf("%0d", w2), "1");
        chk("collision_edge", e2 == e + 11'd4, $sformatf("%0d", e2 - e), "4");
        idle(9);

        // Back-to-back unary ops.
        issue(3'd5, 32'h40490FDB, 32'h0, 5'd3, 32'h00000003, 1, 1, w, e);
        issue(3'd7, 32'hBF800000, 32'h0, 5'd4, 32'h3F800000, 1, 1, w2, e2);
        chk("b2b_edge", e2 == e + 11'd1, $sformatf("%0d", e2 - e), "1");
        idle(5);

        // Missing FPU result.
        issue(3'd2, 32'h40000000, 32'h40400000, 5'd7, 32'h12345678, 0, 1, w, e);
        idle(6);

        // Flush with fdiv in flight: flush sampled at edge E+2.
        issue(3'd3, 32'h40A00000, 32'h40000000, 5'd9, 32'h40200000, 1, 0, w, e);
        idle(1);
        chk("busy_before_flush", busy === 1'b1, $sformatf("%b", busy), "1");
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_tag = 5'd10;
        #1;
        chk("ready_in_flush", req_ready === 1'b0, $sformatf("%b", req_ready), "0");
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        #1;
        chk("ready_after_flush", req_ready === 1'b1, $sformatf("%b", req_ready), "1");
        idle(1);
        chk("busy_after_flush", busy === 1'b0, $sformatf("%b", busy), "0");
        idle(9);

        // Reset with fsqrt in flight.
        issue(3'd4, 32'h40800000, 32'h0, 5'd11, 32'h40000000, 1, 0, w, e);
        idle(1);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset", fpu_opcode === 8'd0 && fpu_x1 === 32'd0 && fpu_x2 === 32'd0 &&
                           resp_valid === 1'b0 && resp_y === 32'd0 && resp_tag === 5'd0 &&
                           resp_err === 1'b0 && busy === 1'b0,
            $sformatf("opc=%h x1=%h rv=%b ry=%h rt=%0d re=%b busy=%b",
                      fpu_opcode, fpu_x1, resp_valid, resp_y, resp_tag, resp_err, busy),
            "all zero");
        idle(2);
        rstn = 1'b1;
        idle(8);
        issue(3'd1, 32'h40400000, 32'h3F800000, 5'd6, 32'h40000000, 1, 1, w, e);
        chk("post_reset_wait", w == 0, $sformatf("%0d", w), "0");
        idle(8);

        chk("queue_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
